// File: rtl/nes_shift_reader.sv
// NES controller poller: latches the pad, clocks out 8 buttons plus a detect bit,
// and publishes the decoded frame with a one-cycle valid pulse.
module nes_shift_reader #(
  parameter int unsigned TICK_CYCLES = 384,
  parameter int unsigned POLL_TICKS  = 2700
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       present,
  output logic       valid
);

  localparam int unsigned TC_W = $clog2(TICK_CYCLES);
  localparam int unsigned PH_W = $clog2((POLL_TICKS > 2) ? POLL_TICKS : 2);
  localparam int unsigned BC_W = 4;
  localparam int unsigned RAW_W = 9;

  localparam logic [TC_W-1:0] TICK_LAST  = TC_W'(TICK_CYCLES - 1);
  localparam logic [PH_W-1:0] POLL_LAST  = PH_W'(POLL_TICKS - 1);
  localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(1);
  localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_PULSE_HI,
    S_PULSE_LO,
    S_WAIT
  } state_t;

  state_t            state, state_nx;
  logic [TC_W-1:0]   tick_cnt, tick_cnt_nx;
  logic [PH_W-1:0]   ph_cnt, ph_cnt_nx;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nx;
  logic [RAW_W-1:0]  raw, raw_nx;
  logic [7:0]        buttons_nx;
  logic              present_nx;
  logic              valid_nx;
  logic              nes_latch_nx;
  logic              nes_clk_nx;
  logic              tick_c;

  // The oldest slot is shifted out on the final sample, so the decode reads the
  // incoming shift value instead of this bit.
  logic unused_raw_oldest;
  assign unused_raw_oldest = raw[0];

  assign tick_c = (state != S_IDLE) && (tick_cnt == TICK_LAST);

  // Next-state, counters, shift register and registered-output next values
  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick_c ? '0 : tick_cnt + TC_W'(1);
    ph_cnt_nx   = ph_cnt;
    bit_cnt_nx  = bit_cnt;
    raw_nx      = raw;
    buttons_nx  = buttons;
    present_nx  = present;
    valid_nx    = 1'b0;

    unique case (state)
      S_IDLE: begin
        tick_cnt_nx = '0;
        ph_cnt_nx   = '0;
        bit_cnt_nx  = '0;
        if (en) state_nx = S_LATCH;
      end
      S_LATCH: begin
        if (tick_c) begin
          if (ph_cnt == LATCH_LAST) begin
            raw_nx     = {nes_data, raw[RAW_W-1:1]};
            ph_cnt_nx  = '0;
            bit_cnt_nx = BC_W'(1);
            state_nx   = S_PULSE_HI;
          end else begin
            ph_cnt_nx = ph_cnt + PH_W'(1);
          end
        end
      end
      S_PULSE_HI: begin
        if (tick_c) state_nx = S_PULSE_LO;
      end
      S_PULSE_LO: begin
        if (tick_c) begin
          raw_nx = {nes_data, raw[RAW_W-1:1]};
          if (bit_cnt == BIT_LAST) begin
            // Data is active-low; a missing pad reads back all ones.
            present_nx = ~raw_nx[8];
            buttons_nx = raw_nx[8] ? 8'h00 : ~raw_nx[7:0];
            valid_nx   = 1'b1;
            state_nx   = S_WAIT;
          end else begin
            bit_cnt_nx = bit_cnt + BC_W'(1);
            state_nx   = S_PULSE_HI;
          end
        end
      end
      S_WAIT: begin
        if (tick_c) begin
          if (ph_cnt == POLL_LAST) begin
            ph_cnt_nx = '0;
            state_nx  = en ? S_LATCH : S_IDLE;
          end else begin
            ph_cnt_nx = ph_cnt + PH_W'(1);
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    nes_latch_nx = (state_nx == S_LATCH);
    nes_clk_nx   = (state_nx == S_PULSE_HI);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      ph_cnt    <= '0;
      bit_cnt   <= '0;
      raw       <= '0;
      buttons   <= 8'h00;
      present   <= 1'b0;
      valid     <= 1'b0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_cnt_nx;
      ph_cnt    <= ph_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      raw       <= raw_nx;
      buttons   <= buttons_nx;
      present   <= present_nx;
      valid     <= valid_nx;
      nes_latch <= nes_latch_nx;
      nes_clk   <= nes_clk_nx;
    end
  end

endmodule

// File: tb/tb_nes_shift_reader.sv
// Directed bench for nes_shift_reader with a reactive controller model
// (TICK_CYCLES=4, POLL_TICKS=8).
module tb_nes_shift_reader;

  localparam int unsigned TC = 4;
  localparam int unsigned PT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       present;
  logic       valid;

  int n_cmp = 0;
  int n_err = 0;

  nes_shift_reader #(.TICK_CYCLES(TC), .POLL_TICKS(PT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_clk  (nes_clk),
    .buttons  (buttons),
    .present  (present),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  // Controller model: latch reloads bit 0, each nes_clk rise advances one bit
  logic [8:0] pat;
  int         idx = 9;
  logic       mclk_q = 1'b0;
  always @(posedge clk) begin
    if (nes_latch) idx <= 0;
    else if (nes_clk && !mclk_q) idx <= idx + 1;
    mclk_q <= nes_clk;
  end
  assign nes_data = (idx < 9) ? pat[idx] : 1'b1;

  // Bus monitor sampled on the falling edge
  int cyc = 0, latch_rises = 0, latch_hi = 0, clk_pulses = 0, bad_len = 0;
  int valid_cnt = 0, overlap = 0, run = 0, rise_prev = 0, rise_last = 0;
  logic latch_q = 1'b0, clk_q = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (nes_latch && !latch_q) begin
      latch_rises = latch_rises + 1;
      rise_prev = rise_last;
      rise_last = cyc;
    end
    if (nes_latch) latch_hi = latch_hi + 1;
    if (nes_clk && !clk_q) begin
      clk_pulses = clk_pulses + 1;
      run = 1;
    end else if (nes_clk) begin
      run = run + 1;
    end
    if (!nes_clk && clk_q && run != TC) bad_len = bad_len + 1;
    if (valid) valid_cnt = valid_cnt + 1;
    if (nes_latch && nes_clk) overlap = overlap + 1;
    latch_q = nes_latch;
    clk_q = nes_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit ok;
  int v0, h0, p0, b0, r0, n;
  logic prev;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    pat   = 9'h07E;

    // Reset state
    step(3);
    check("rst_latch", 32'(nes_latch), 32'd0);
    check("rst_clk", 32'(nes_clk), 32'd0);
    check("rst_buttons", 32'(buttons), 32'h00);
    check("rst_present", 32'(present), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    r0 = latch_rises;
    step(200);
    check("idle_no_latch", 32'(latch_rises - r0), 32'd0);
    check("idle_buttons", 32'(buttons), 32'h00);

    // Single frame, A + Right pressed
    v0 = valid_cnt; h0 = latch_hi; p0 = clk_pulses; b0 = bad_len; r0 = latch_rises;
    en = 1'b1;
    step(1);
    check("latch_start", 32'(nes_latch), 32'd1);
    en = 1'b0;
    wait_valid(ok);
    check("f1_valid_seen", 32'(ok), 32'd1);
    check("f1_buttons", 32'(buttons), 32'h81);
    check("f1_present", 32'(present), 32'd1);
    step(40);
    check("f1_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("f1_latch_cycles", 32'(latch_hi - h0), 32'd8);
    check("f1_clk_pulses", 32'(clk_pulses - p0), 32'd8);
    check("f1_clk_width", 32'(bad_len - b0), 32'd0);
    check("f1_latch_rises", 32'(latch_rises - r0), 32'd1);
    check("hold_buttons", 32'(buttons), 32'h81);
    check("hold_present", 32'(present), 32'd1);

    // No controller
    pat = 9'h1FF;
    en = 1'b1;
    step(1);
    en = 1'b0;
    wait_valid(ok);
    check("nc_valid_seen", 32'(ok), 32'd1);
    check("nc_buttons", 32'(buttons), 32'h00);
    check("nc_present", 32'(present), 32'd0);
    step(40);

    // Continuous polling, then pattern change to A only
    pat = 9'h07E;
    en = 1'b1;
    wait_valid(ok);
    check("cont1_valid_seen", 32'(ok), 32'd1);
    check("cont1_buttons", 32'(buttons), 32'h81);
    pat = 9'h0FE;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      n++;
      if (nes_latch) break;
    end
    check("wait_length", 32'(n), 32'd32);
    wait_valid(ok);
    check("cont2_valid_seen", 32'(ok), 32'd1);
    check("cont2_buttons", 32'(buttons), 32'h01);
    check("cont2_present", 32'(present), 32'd1);
    check("frame_period", 32'(rise_last - rise_prev), 32'd104);
    en = 1'b0;
    step(40);
    r0 = latch_rises;
    step(150);
    check("cont_stop_no_latch", 32'(latch_rises - r0), 32'd0);

    // en dropped during PULSE_HI k=3
    pat = 9'h07E;
    en = 1'b1;
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (nes_clk && !prev) n++;
      prev = nes_clk;
      if (n == 3) break;
    end
    check("k3_reached", 32'(n), 32'd3);
    en = 1'b0;
    wait_valid(ok);
    check("k3_valid_seen", 32'(ok), 32'd1);
    check("k3_buttons", 32'(buttons), 32'h81);
    r0 = latch_rises;
    step(200);
    check("k3_no_relatch", 32'(latch_rises - r0), 32'd0);

    // Asynchronous reset during PULSE_HI
    en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (nes_clk) begin
        ok = 1'b1;
        break;
      end
    end
    check("pulse_hi_reached", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_clk", 32'(nes_clk), 32'd0);
    check("arst_buttons", 32'(buttons), 32'h00);
    check("arst_present", 32'(present), 32'd0);
    check("arst_latch", 32'(nes_latch), 32'd0);
    step(2);
    rst_n = 1'b1;
    wait_valid(ok);
    check("post_rst_valid_seen", 32'(ok), 32'd1);
    check("post_rst_buttons", 32'(buttons), 32'h81);
    check("post_rst_present", 32'(present), 32'd1);
    en = 1'b0;
    step(50);
    check("latch_clk_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
